reg_share_arbiter: RTL and testbench

//   Round-robin arbiter sharing one WIDTH-bit D-flip-flop register (Q) among NREQ

---
 rtl/reg_share_arbiter.sv | 131 +++++++++++++
 tb/tb_reg_share_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that is the sole writer of one shared WIDTH-bit register Q.
// Latency: req seen in IDLE -> gnt next cycle -> Q/q_valid the cycle after.
// Backpressure: requests are ignored while busy (GRANT and HOLD cool-down cycles).
// Optional feature macro: REG_SHARE_STATS_EN adds a saturating 16-bit wr_count port.
module reg_share_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  parameter  int HOLD  = 2,
  localparam int PW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       gnt,
  output logic [PW-1:0]         owner,
`ifdef REG_SHARE_STATS_EN
  output logic [15:0]           wr_count,
`endif
  output logic [WIDTH-1:0]      Q,
  output logic                  q_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, GRANT, COOL} state_t;

  state_t           state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic [PW-1:0]    ptr, ptr_nx;
  logic [NREQ-1:0]  gnt_nx;
  logic [PW-1:0]    owner_nx;
  logic [WIDTH-1:0] q_nx;
  logic             q_valid_nx;

  logic             pick_vld;
  logic [PW-1:0]    pick_idx;
  logic [PW-1:0]    cand;

  // Round-robin search starting at ptr; scanning backwards lets the slot
  // nearest to ptr overwrite any farther hit, so no early exit is needed.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr;
    cand     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next-state and next-output logic for the IDLE/GRANT/COOL sequence.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ptr_nx     = ptr;
    gnt_nx     = '0;
    owner_nx   = owner;
    q_nx       = Q;
    q_valid_nx = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          gnt_nx   = NREQ'(1) << pick_idx;
          owner_nx = pick_idx;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        // A withdrawn request aborts the write but still advances the pointer.
        if (req[owner]) begin
          q_nx       = wr_data[owner*WIDTH +: WIDTH];
          q_valid_nx = 1'b1;
        end
        ptr_nx = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
        if (HOLD > 0) begin
          state_nx = COOL;
          cnt_nx   = 4'(HOLD);
        end else begin
          state_nx = IDLE;
        end
      end
      COOL: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= '0;
      gnt     <= '0;
      owner   <= '0;
      Q       <= '0;
      q_valid <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      ptr     <= ptr_nx;
      gnt     <= gnt_nx;
      owner   <= owner_nx;
      Q       <= q_nx;
      q_valid <= q_valid_nx;
    end
  end

  assign busy = (state != IDLE);

`ifdef REG_SHARE_STATS_EN
  // Saturating count of committed writes; aborts never raise q_valid_nx.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
    end else if (q_valid_nx && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter (NREQ=4, WIDTH=8, HOLD=2).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Expected values are hand-derived constants.
module tb_reg_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wr_data;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [7:0]  Q;
  logic        q_valid;
  logic        busy;
`ifdef REG_SHARE_STATS_EN
  logic [15:0] wr_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  reg_share_arbiter #(.NREQ(4), .WIDTH(8), .HOLD(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wr_data  (wr_data),
    .gnt      (gnt),
    .owner    (owner),
`ifdef REG_SHARE_STATS_EN
    .wr_count (wr_count),
`endif
    .Q        (Q),
    .q_valid  (q_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    req     = 4'hF;
    wr_data = 32'h13121110;

    // 1. Reset held with all requests pending: nothing may be granted.
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_gnt",   32'(gnt),     32'h0);
      check("rst_q",     32'(Q),       32'h0);
      check("rst_qv",    32'(q_valid), 32'h0);
      check("rst_busy",  32'(busy),    32'h0);
      check("rst_owner", 32'(owner),   32'h0);
    end
    rst = 1'b0;
    tick();
    check("first_gnt", 32'(gnt), 32'h1);

    // 2. Single write from requester 2.
    do_reset();
    wr_data = 32'h00A50000;
    req     = 4'b0100;
    tick();
    check("sw_gnt",   32'(gnt),   32'h4);
    check("sw_owner", 32'(owner), 32'h2);
    check("sw_busy1", 32'(busy),  32'h1);
    tick();
    req = 4'b0000;
    check("sw_q",     32'(Q),       32'hA5);
    check("sw_qv",    32'(q_valid), 32'h1);
    check("sw_gnt0",  32'(gnt),     32'h0);
    check("sw_busy2", 32'(busy),    32'h1);
    tick();
    check("sw_qv0",   32'(q_valid), 32'h0);
    check("sw_busy3", 32'(busy),    32'h1);
    tick();
    check("sw_busy4", 32'(busy),  32'h0);
    check("sw_ownk",  32'(owner), 32'h2);
    check("sw_qhold", 32'(Q),     32'hA5);

    // 4. Abort: ptr is now 3, so req[1] wins after wrapping; withdrawing it
    //    during the grant leaves Q alone and moves ptr to 2.
    wr_data = 32'h00A57700;
    req     = 4'b0010;
    tick();
    check("ab_gnt",   32'(gnt),   32'h2);
    check("ab_owner", 32'(owner), 32'h1);
    req = 4'b0000;
    tick();
    check("ab_q",  32'(Q),       32'hA5);
    check("ab_qv", 32'(q_valid), 32'h0);
    check("ab_g0", 32'(gnt),     32'h0);
    tick();
    check("ab_qv2", 32'(q_valid), 32'h0);
    tick();
    check("ab_idle", 32'(busy), 32'h0);
    wr_data = 32'h13121110;
    req     = 4'hF;
    tick();
    check("ab_next_gnt", 32'(gnt), 32'h4);
    tick();
    req = 4'h0;
    check("ab_next_q",  32'(Q),       32'h12);
    check("ab_next_qv", 32'(q_valid), 32'h1);
    tick();
    tick();
`ifdef REG_SHARE_STATS_EN
    check("stat_cnt", 32'(wr_count), 32'd2);
`endif

    // 3. Round-robin with all requests held: one commit every 4 cycles.
    do_reset();
    wr_data = 32'h13121110;
    req     = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_gnt",  32'(gnt),   32'(4'b0001 << (k % 4)));
      check("rr_own",  32'(owner), 32'(k % 4));
      tick();
      check("rr_q",    32'(Q),       32'h10 + 32'(k % 4));
      check("rr_qv",   32'(q_valid), 32'h1);
      tick();
      check("rr_qv0",  32'(q_valid), 32'h0);
      check("rr_g0",   32'(gnt),     32'h0);
      tick();
      check("rr_idle", 32'(busy),    32'h0);
    end

    // 5. Reset during GRANT kills the pending write.
    do_reset();
    wr_data = 32'h0000003C;
    req     = 4'b0001;
    tick();
    check("mr_gnt", 32'(gnt), 32'h1);
    rst = 1'b1;
    tick();
    check("mr_q",    32'(Q),       32'h0);
    check("mr_gnt0", 32'(gnt),     32'h0);
    check("mr_qv",   32'(q_valid), 32'h0);
    check("mr_busy", 32'(busy),    32'h0);
    rst = 1'b0;
    req = 4'b0000;
    tick();
    check("mr_qv2", 32'(q_valid), 32'h0);
    check("mr_q2",  32'(Q),       32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
